// File: rtl/video_burst_sched.sv
// Frame scan-out read scheduler: issues AXI read bursts into a pixel FIFO while keeping
// FIFO occupancy plus in-flight beats within FIFO_DEPTH. Optional VIDEO_BURST_SCHED_STATS_EN adds counters.
module video_burst_sched #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned BEAT_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          frame_req_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [15:0]                   frame_bursts_i,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_level_i,
  output logic [ADDR_WIDTH-1:0]         ar_addr_o,
  output logic [7:0]                    ar_len_o,
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,
  input  logic                          r_valid_i,
  input  logic                          r_ready_i,
  output logic                          sof_o,
  output logic                          busy_o,
  output logic                          overrun_o
`ifdef VIDEO_BURST_SCHED_STATS_EN
  ,
  output logic [31:0]                   frame_cnt_o,
  output logic [31:0]                   stall_cnt_o
`endif
);

  localparam int unsigned OUTST_W = $clog2(MAX_OUTST * BURST_LEN + 1);
  localparam int unsigned OB_W    = $clog2(MAX_OUTST + 1);
  localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned SUM_W   = 34;
  localparam int unsigned STEP    = BURST_LEN * BEAT_BYTES;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, ADDR, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           remain_q, remain_d;
  logic [OUTST_W-1:0]    outst_beats_q, outst_beats_d;
  logic [OB_W-1:0]       outst_bursts_q, outst_bursts_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  ar_valid_q, ar_valid_d;
  logic                  sof_q, sof_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic beat_fire;
  logic ar_fire;
  logic last_beat;
  logic space_ok;

  // Handshake decode and FIFO headroom test, widened so the sum cannot wrap
  always_comb begin
    beat_fire = r_valid_i & r_ready_i & (outst_beats_q != '0);
    ar_fire   = ar_valid_q & ar_ready_i;
    last_beat = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
    space_ok  = ((SUM_W'(fifo_level_i) + SUM_W'(outst_beats_q) + SUM_W'(BURST_LEN))
                 <= SUM_W'(FIFO_DEPTH)) && (outst_bursts_q < OB_W'(MAX_OUTST));
  end

  // In-flight beat/burst bookkeeping
  always_comb begin
    outst_beats_d  = outst_beats_q;
    outst_bursts_d = outst_bursts_q;
    beat_cnt_d     = beat_cnt_q;
    if (ar_fire) begin
      outst_beats_d  = outst_beats_d + OUTST_W'(BURST_LEN);
      outst_bursts_d = outst_bursts_d + OB_W'(1);
    end
    if (beat_fire) begin
      outst_beats_d = outst_beats_d - OUTST_W'(1);
      if (last_beat) begin
        beat_cnt_d     = '0;
        outst_bursts_d = outst_bursts_d - OB_W'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    ar_valid_d = ar_valid_q;
    sof_d      = sof_q & ~beat_fire;
    overrun_d  = frame_req_i & (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (frame_req_i && enable_i && (frame_bursts_i != 16'd0)) begin
          addr_d   = base_addr_i;
          remain_d = frame_bursts_i;
          sof_d    = 1'b1;
          state_d  = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (!enable_i) begin
          state_d = DRAIN;
        end else if (space_ok) begin
          ar_valid_d = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        // Request stays up regardless of enable_i until accepted
        if (ar_fire) begin
          ar_valid_d = 1'b0;
          addr_d     = addr_q + ADDR_WIDTH'(STEP);
          remain_d   = remain_q - 16'd1;
          state_d    = ((remain_q == 16'd1) || !enable_i) ? DRAIN : WAIT_SPACE;
        end
      end
      DRAIN: begin
        if (outst_beats_q == '0) begin
          sof_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      remain_q       <= '0;
      outst_beats_q  <= '0;
      outst_bursts_q <= '0;
      beat_cnt_q     <= '0;
      ar_valid_q     <= 1'b0;
      sof_q          <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remain_q       <= remain_d;
      outst_beats_q  <= outst_beats_d;
      outst_bursts_q <= outst_bursts_d;
      beat_cnt_q     <= beat_cnt_d;
      ar_valid_q     <= ar_valid_d;
      sof_q          <= sof_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign ar_addr_o  = addr_q;
  assign ar_len_o   = 8'(BURST_LEN - 1);
  assign ar_valid_o = ar_valid_q;
  assign sof_o      = sof_q;
  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;

`ifdef VIDEO_BURST_SCHED_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating completed-frame and headroom-stall counters
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == DRAIN) && (state_d == IDLE) && (frame_cnt_q != '1))
      frame_cnt_d = frame_cnt_q + 32'd1;
    if ((state_q == WAIT_SPACE) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_video_burst_sched.sv
// Scoreboard bench for video_burst_sched: expected AR addresses are queued by the
// stimulus and popped by an AR monitor; a simple read slave returns beats.
module tb_video_burst_sched;

  localparam int unsigned AW = 32;
  localparam int unsigned BL = 256;
  localparam int unsigned FD = 512;
  localparam int unsigned LW = $clog2(FD) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          frame_req_i;
  logic [AW-1:0] base_addr_i;
  logic [15:0]   frame_bursts_i;
  logic [LW-1:0] fifo_level_i;
  logic [AW-1:0] ar_addr_o;
  logic [7:0]    ar_len_o;
  logic          ar_valid_o;
  logic          ar_ready_i;
  logic          r_valid_i;
  logic          r_ready_i;
  logic          sof_o;
  logic          busy_o;
  logic          overrun_o;
`ifdef VIDEO_BURST_SCHED_STATS_EN
  logic [31:0]   frame_cnt_o;
  logic [31:0]   stall_cnt_o;
`endif

  video_burst_sched dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .frame_req_i    (frame_req_i),
    .base_addr_i    (base_addr_i),
    .frame_bursts_i (frame_bursts_i),
    .fifo_level_i   (fifo_level_i),
    .ar_addr_o      (ar_addr_o),
    .ar_len_o       (ar_len_o),
    .ar_valid_o     (ar_valid_o),
    .ar_ready_i     (ar_ready_i),
    .r_valid_i      (r_valid_i),
    .r_ready_i      (r_ready_i),
    .sof_o          (sof_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o)
`ifdef VIDEO_BURST_SCHED_STATS_EN
    ,
    .frame_cnt_o    (frame_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [AW-1:0] exp_addr[$];
  int pass_cnt   = 0;
  int total_cnt  = 0;
  int pending    = 0;
  int beat_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input int n);
    base_addr_i    = base;
    frame_bursts_i = 16'(n);
    frame_req_i    = 1'b1;
    tick(1);
    frame_req_i    = 1'b0;
  endtask

  task automatic wait_idle(input string nm, output int av_cnt);
    av_cnt = 0;
    for (int i = 0; i < 4000 && busy_o; i++) begin
      tick(1);
      if (ar_valid_o) av_cnt++;
    end
    check(nm, 64'(busy_o), 64'd0);
  endtask

  task automatic wait_arv(input string nm);
    for (int i = 0; i < 50 && !ar_valid_o; i++) tick(1);
    check(nm, 64'(ar_valid_o), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ar_valid"}, 64'(ar_valid_o), 64'd0);
    check({tag, "_ar_addr"},  64'(ar_addr_o),  64'd0);
    check({tag, "_ar_len"},   64'(ar_len_o),   64'hFF);
    check({tag, "_sof"},      64'(sof_o),      64'd0);
    check({tag, "_busy"},     64'(busy_o),     64'd0);
    check({tag, "_overrun"},  64'(overrun_o),  64'd0);
  endtask

  // AR monitor: every accepted request must match the head of the scoreboard
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(negedge clk_i);
      if (!rst_i && ar_valid_o && ar_ready_i) begin
        if (exp_addr.size() == 0) begin
          total_cnt++;
          $display("FAIL ar_unexpected: got addr 0x%0h, expected no request", ar_addr_o);
        end else begin
          a = exp_addr.pop_front();
          check("ar_addr", 64'(ar_addr_o), 64'(a));
          check("ar_len",  64'(ar_len_o),  64'hFF);
        end
      end
    end
  end

  // Read slave: each accepted burst queues BL beats, streamed back-to-back
  initial begin
    logic hs, bt;
    r_valid_i = 1'b0;
    forever begin
      @(negedge clk_i);
      hs = ar_valid_o && ar_ready_i && !rst_i;
      bt = r_valid_i && r_ready_i;
      @(posedge clk_i);
      #1;
      if (rst_i) pending = 0;
      else begin
        if (hs) pending += BL;
        if (bt && pending > 0) begin
          pending--;
          beat_total++;
        end
      end
      r_valid_i = (pending > 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int av, cnt, stable, b0;
    logic [AW-1:0] a0;
    rst_i = 1'b1; enable_i = 1'b1; frame_req_i = 1'b0;
    base_addr_i = '0; frame_bursts_i = '0; fifo_level_i = '0;
    ar_ready_i = 1'b1; r_ready_i = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    tick(1);

    // Four-burst frame, free FIFO
    b0 = beat_total;
    exp_addr.push_back(32'h1000_0000); exp_addr.push_back(32'h1000_0400);
    exp_addr.push_back(32'h1000_0800); exp_addr.push_back(32'h1000_0C00);
    start_frame(32'h1000_0000, 4);
    check("frame4_sof_set", 64'(sof_o), 64'd1);
    check("frame4_busy", 64'(busy_o), 64'd1);
    check("frame4_no_overrun", 64'(overrun_o), 64'd0);
    wait_idle("frame4_idle", av);
    check("frame4_beats", 64'(beat_total - b0), 64'd1024);
    check("frame4_sof_clear", 64'(sof_o), 64'd0);
    check("frame4_ar_done", 64'(exp_addr.size()), 64'd0);

    // FIFO headroom boundary: 257 blocks, 256 admits
    fifo_level_i = LW'(257);
    exp_addr.push_back(32'h2000_0000);
    start_frame(32'h2000_0000, 1);
    cnt = 0;
    repeat (20) begin
      tick(1);
      if (ar_valid_o) cnt++;
    end
    check("level257_no_ar", 64'(cnt), 64'd0);
    fifo_level_i = LW'(256);
    tick(1);
    check("level256_ar_valid", 64'(ar_valid_o), 64'd1);
    wait_idle("level_idle", av);
    fifo_level_i = '0;

    // Stalled AR with enable dropped mid-request
    ar_ready_i = 1'b0;
    exp_addr.push_back(32'h3000_0000);
    start_frame(32'h3000_0000, 3);
    wait_arv("stall_arv");
    a0 = ar_addr_o;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) enable_i = 1'b0;
      tick(1);
      if (ar_valid_o && ar_addr_o == a0) stable++;
    end
    check("stall_stable", 64'(stable), 64'd10);
    check("stall_addr", 64'(a0), 64'h3000_0000);
    ar_ready_i = 1'b1;
    tick(1);
    wait_idle("disable_idle", av);
    check("disable_no_more_ar", 64'(av), 64'd0);
    enable_i = 1'b1;

    // Address wrap at 2^32
    exp_addr.push_back(32'hFFFF_FC00); exp_addr.push_back(32'h0000_0000);
    start_frame(32'hFFFF_FC00, 2);
    wait_idle("wrap_idle", av);

    // Overrun while waiting for space, then zero-burst request
    fifo_level_i = LW'(300);
    exp_addr.push_back(32'h4000_0000);
    start_frame(32'h4000_0000, 1);
    check("overrun_quiet", 64'(overrun_o), 64'd0);
    base_addr_i = 32'h5000_0000; frame_bursts_i = 16'd5; frame_req_i = 1'b1;
    tick(1);
    frame_req_i = 1'b0;
    check("overrun_pulse", 64'(overrun_o), 64'd1);
    tick(1);
    check("overrun_single", 64'(overrun_o), 64'd0);
    fifo_level_i = '0;
    wait_idle("overrun_idle", av);
    start_frame(32'h4800_0000, 0);
    check("zero_bursts_busy0", 64'(busy_o), 64'd0);
    tick(1);
    check("zero_bursts_busy1", 64'(busy_o), 64'd0);

    // Reset while a request is pending
    ar_ready_i = 1'b0;
    start_frame(32'h6000_0000, 2);
    wait_arv("rst_arv");
    rst_i = 1'b1;
    tick(1);
    check_reset_outputs("midrst");
    rst_i = 1'b0;
    ar_ready_i = 1'b1;
    tick(3);
    check("midrst_stays_idle", 64'(busy_o), 64'd0);
    check("midrst_no_ar", 64'(ar_valid_o), 64'd0);

`ifdef VIDEO_BURST_SCHED_STATS_EN
    for (int f = 0; f < 3; f++) begin
      exp_addr.push_back(32'h7000_0000 + 32'(f) * 32'h1000);
      start_frame(32'h7000_0000 + 32'(f) * 32'h1000, 1);
      wait_idle("stats_idle", av);
    end
    check("stats_frame_cnt", 64'(frame_cnt_o), 64'd3);
    check("stats_stall_cnt", 64'(stall_cnt_o), 64'd3);
`endif

    tick(2);
    check("scoreboard_empty", 64'(exp_addr.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/video_burst_sched.md
VIDEO_BURST_SCHED -- requirements
Module: video_burst_sched

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI read address width.
REQ-002 SHALL have parameter BURST_LEN, default 256, beats per burst (power of 2, 1..256).
REQ-003 SHALL have parameter BEAT_BYTES, default 4, bytes per beat.
REQ-004 SHALL have parameter FIFO_DEPTH, default 512, pixel FIFO depth in beats.
REQ-005 SHALL have parameter MAX_OUTST, default 2, maximum bursts in flight.
REQ-006 SHALL have ports: clk_i  in  1  single clock; rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: enable_i  in  1  scan-out enable; frame_req_i  in  1  one-cycle frame-start pulse, already synchronized to clk_i.
REQ-008 SHALL have ports: base_addr_i  in  ADDR_WIDTH  frame base; frame_bursts_i  in  16  bursts per frame.
REQ-009 SHALL have ports: fifo_level_i  in  $clog2(FIFO_DEPTH)+1  FIFO beats occupied.
REQ-010 SHALL have ports: ar_addr_o  out  ADDR_WIDTH; ar_len_o  out  8  (BURST_LEN-1); ar_valid_o  out  1; ar_ready_i  in  1.
REQ-011 SHALL have ports: r_valid_i  in  1; r_ready_i  in  1  read-data beat handshake observed.
REQ-012 SHALL have ports: sof_o  out  1  marks the first beat of a frame; busy_o  out  1  frame active; overrun_o  out  1  one-cycle pulse.

Function
REQ-013 SHALL implement states IDLE, WAIT_SPACE, ADDR, DRAIN.
REQ-014 IDLE: on frame_req_i=1 with enable_i=1, SHALL latch base_addr_i and frame_bursts_i and go to WAIT_SPACE; if frame_bursts_i=0, SHALL stay in IDLE.
REQ-015 WAIT_SPACE SHALL go to ADDR when fifo_level_i + outst_beats + BURST_LEN <= FIFO_DEPTH and outst_bursts < MAX_OUTST; comparison SHALL use width without overflow.
REQ-016 ar_valid_o SHALL be registered, high in the cycle after the space condition holds, and held with stable ar_addr_o/ar_len_o until ar_ready_i=1.
REQ-017 On AR handshake, address SHALL advance by BURST_LEN*BEAT_BYTES modulo 2^ADDR_WIDTH, remaining-burst count decrement, outst_beats increase by BURST_LEN.
REQ-018 outst_beats SHALL decrement by 1 per r_valid_i&r_ready_i; simultaneous AR handshake and beat SHALL net +BURST_LEN-1; outst_bursts SHALL decrement when a burst's last beat completes.
REQ-019 After the final AR handshake, or when enable_i=0 outside ADDR, SHALL go to DRAIN; DRAIN SHALL go to IDLE when outst_beats=0.
REQ-020 enable_i falling during ADDR SHALL NOT drop ar_valid_o; the pending handshake completes, then DRAIN.
REQ-021 sof_o SHALL be 1 from frame latch until the first r_valid_i&r_ready_i of that frame, inclusive.
REQ-022 frame_req_i outside IDLE SHALL be ignored and SHALL pulse overrun_o for one cycle, one cycle later.
REQ-023 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-024 rst_i SHALL force IDLE, ar_valid_o=0, ar_addr_o=0, ar_len_o=BURST_LEN-1, sof_o=0, busy_o=0, overrun_o=0, all counters 0; reset mid-burst SHALL abandon in-flight beats with no recovery attempt.

Configuration
REQ-025 With VIDEO_BURST_SCHED_STATS_EN defined, SHALL add outputs frame_cnt_o (32) counting frames reaching IDLE from DRAIN, and stall_cnt_o (32) counting cycles in WAIT_SPACE, both saturating and reset to 0 by rst_i.
REQ-026 Without VIDEO_BURST_SCHED_STATS_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-027 Base 0x1000_0000, 4 bursts, level 0, ar_ready_i=1, r always ready -> AR addresses 0x1000_0000/0400/0800/0C00, ar_len_o=0xFF, busy_o low after 1024 beats.
REQ-028 fifo_level_i=257 held -> no ar_valid_o; level 256 -> ar_valid_o in the next cycle.
REQ-029 ar_ready_i held low 10 cycles -> ar_valid_o and ar_addr_o stable 10 cycles; enable_i dropped meanwhile -> one handshake, DRAIN, IDLE.
REQ-030 Base 0xFFFF_FC00, 2 bursts -> addresses 0xFFFF_FC00 then 0x0000_0000.
REQ-031 frame_req_i during WAIT_SPACE -> overrun_o one-cycle pulse, frame unaffected; frame_bursts_i=0 -> busy_o stays 0.
REQ-032 rst_i asserted mid-ADDR -> next cycle all outputs at reset values; with STATS_EN, 3 frames -> frame_cnt_o=3.
